// File: rtl/tx_pkg.sv
// Shared types and line constants for the serial frame transmit/receive pair.
package tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake between a producer and the serial frame transmitter.
interface serial_frame_tx_if #(
   parameter int unsigned DATA_W = 8
) ();

   logic [DATA_W-1:0] IN_DATA;
   logic              IN_VALID;
   logic              IN_READY;

   modport master (output IN_DATA, output IN_VALID, input IN_READY);
   modport slave  (input IN_DATA, input IN_VALID, output IN_READY);

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period counter: ticks on the last cycle of every CLKS_PER_BIT-cycle period.
module bit_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_c_o,
   output logic tick_next_c_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // tick_next lets the owner register outputs that must line up with the tick
   assign tick_c_o      = en_i && (cnt_q == LAST_CNT);
   assign tick_next_c_o = (cnt_d == LAST_CNT);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, data LSB first, optional
// even parity, STOP_BITS stop bits, each bit held CLKS_PER_BIT cycles.
module serial_frame_tx
   import tx_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic             CLK,
   input  logic             RST,
   serial_frame_tx_if.slave in_if,
   output logic             OUT,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              out_q, out_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic accept_c;
   logic tick_c;
   logic tick_next_c;

   assign accept_c = in_if.IN_VALID && ready_q;

   bit_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .CLK          (CLK),
      .RST          (RST),
      .en_i         (state_q != IDLE),
      .clr_i        (accept_c),
      .tick_c_o     (tick_c),
      .tick_next_c_o(tick_next_c)
   );

   // Next state; bit_q counts data bits in DATA and stop bits in STOP
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_d   = bit_q;
      out_d   = LINE_IDLE;
      ready_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               shift_d = in_if.IN_DATA;
               par_d   = ^in_if.IN_DATA;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (tick_c) state_d = DATA;
         end
         DATA: begin
            if (tick_c) begin
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (tick_c) state_d = STOP;
         end
         STOP: begin
            if (tick_c) begin
               if (bit_q == LAST_STOP) begin
                  bit_d   = '0;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so they are registered in step
      unique case (state_d)
         START:   out_d = START_BIT;
         DATA:    out_d = shift_d[0];
         PARITY:  out_d = par_d;
         default: out_d = LINE_IDLE;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == STOP) && (bit_d == LAST_STOP) && tick_next_c;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         shift_q <= '0;
         par_q   <= 1'b0;
         bit_q   <= '0;
         out_q   <= LINE_IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         bit_q   <= bit_d;
         out_q   <= out_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign in_if.IN_READY = ready_q;
   assign OUT            = out_q;
   assign BUSY           = busy_q;
   assign DONE           = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: dut_a uses defaults, dut_b uses CLKS_PER_BIT=1, no parity, 2 stops.
module tb_serial_frame_tx;

   typedef struct {
      logic [63:0] bits;
      int          len;
      logic [7:0]  data;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   logic out_a, busy_a, done_a;
   logic out_b, busy_b, done_b;

   int tests = 0;
   int fails = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t cur[2];
   bit   act[2];
   bit   post[2];
   int   idx[2];
   int   ferr[2];

   serial_frame_tx_if #(.DATA_W(8)) a_if ();
   serial_frame_tx_if #(.DATA_W(8)) b_if ();

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
      .CLK(CLK), .RST(RST), .in_if(a_if), .OUT(out_a), .BUSY(busy_a), .DONE(done_a));

   serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
      .CLK(CLK), .RST(RST), .in_if(b_if), .OUT(out_b), .BUSY(busy_b), .DONE(done_b));

   always #5 CLK = ~CLK;

   // Reference frame: list of line bits expanded to one entry per clock cycle
   function automatic exp_t model(input logic [7:0] d, input int cpb, input int pen, input int sb);
      exp_t e;
      logic [15:0] b;
      int nb;
      int ones;
      b = '0; nb = 0; ones = 0;
      e.bits = '0; e.len = 0; e.data = d;
      b[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
         b[nb] = d[i];
         if (d[i]) ones++;
         nb++;
      end
      if (pen != 0) begin b[nb] = ((ones % 2) == 1); nb++; end
      for (int i = 0; i < sb; i++) begin b[nb] = 1'b1; nb++; end
      for (int j = 0; j < nb; j++)
         for (int c = 0; c < cpb; c++) begin e.bits[e.len] = b[j]; e.len++; end
      return e;
   endfunction

   function automatic logic outv(input int k);  return (k == 0) ? out_a : out_b;  endfunction
   function automatic logic busyv(input int k); return (k == 0) ? busy_a : busy_b; endfunction
   function automatic logic donev(input int k); return (k == 0) ? done_a : done_b; endfunction
   function automatic logic rdy(input int k);   return (k == 0) ? a_if.IN_READY : b_if.IN_READY; endfunction

   task automatic drive(input int k, input logic [7:0] d, input logic v);
      if (k == 0) begin a_if.IN_DATA = d; a_if.IN_VALID = v; end
      else        begin b_if.IN_DATA = d; b_if.IN_VALID = v; end
   endtask

   task automatic chk(input string name, input logic got, input logic want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   // Stimulus side of the scoreboard: every accepted word queues its expected frame
   always @(posedge CLK) begin
      if (RST) begin
         if (a_if.IN_VALID && a_if.IN_READY) q0.push_back(model(a_if.IN_DATA, 4, 1, 1));
         if (b_if.IN_VALID && b_if.IN_READY) q1.push_back(model(b_if.IN_DATA, 1, 0, 2));
      end
   end

   // Monitor: pops an expected frame when BUSY rises and checks it cycle by cycle
   always @(negedge CLK) begin
      for (int k = 0; k < 2; k++) begin
         if (!RST) begin
            tests++;
            if (outv(k) !== 1'b1 || busyv(k) !== 1'b0 || donev(k) !== 1'b0 || rdy(k) !== 1'b0) begin
               fails++;
               $display("FAIL reset_vals dut%0d: out=%b busy=%b done=%b ready=%b want 1 0 0 0",
                        k, outv(k), busyv(k), donev(k), rdy(k));
            end
            act[k] = 1'b0; post[k] = 1'b0;
            if (k == 0) q0.delete(); else q1.delete();
         end else begin
            if (!act[k] && busyv(k) === 1'b1) begin
               tests++;
               if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                  fails++;
                  $display("FAIL unexpected_frame dut%0d: busy=1 with no accepted word pending", k);
               end else begin
                  cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                  act[k] = 1'b1; idx[k] = 0; ferr[k] = 0;
               end
            end
            if (act[k]) begin
               if (outv(k) !== cur[k].bits[idx[k]] || busyv(k) !== 1'b1 ||
                   donev(k) !== (idx[k] == cur[k].len - 1) || rdy(k) !== 1'b0) begin
                  if (ferr[k] == 0)
                     $display("FAIL frame dut%0d data=%h cycle %0d: out=%b busy=%b done=%b ready=%b want %b 1 %b 0",
                              k, cur[k].data, idx[k], outv(k), busyv(k), donev(k), rdy(k),
                              cur[k].bits[idx[k]], (idx[k] == cur[k].len - 1));
                  ferr[k]++;
               end
               idx[k]++;
               if (idx[k] == cur[k].len) begin
                  tests++;
                  if (ferr[k] != 0) fails++;
                  act[k] = 1'b0; post[k] = 1'b1;
               end
            end else if (busyv(k) === 1'b0) begin
               tests++;
               if (outv(k) !== 1'b1 || donev(k) !== 1'b0 || (post[k] && rdy(k) !== 1'b1)) begin
                  fails++;
                  $display("FAIL idle dut%0d: out=%b done=%b ready=%b want 1 0 %s",
                           k, outv(k), donev(k), rdy(k), post[k] ? "1" : "-");
               end
               post[k] = 1'b0;
            end
         end
      end
   end

   // Offers a word, waits for the handshake, checks start-bit latency, then adds noise
   task automatic send(input int k, input logic [7:0] d, input int noise, input bit hold);
      bit ok;
      ok = 1'b0;
      @(negedge CLK);
      drive(k, d, 1'b1);
      for (int i = 0; i < 300 && !ok; i++) begin
         if (rdy(k)) ok = 1'b1;
         else @(negedge CLK);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL accept_timeout dut%0d: ready=0 want 1", k);
         drive(k, d, 1'b0);
      end else begin
         @(negedge CLK);
         chk($sformatf("start_latency_busy dut%0d", k), busyv(k), 1'b1);
         chk($sformatf("start_latency_out dut%0d", k), outv(k), 1'b0);
         if (!hold) drive(k, d, 1'b0);
         for (int i = 0; i < noise; i++) begin
            @(negedge CLK);
            drive(k, 8'($urandom), 1'($urandom % 2));
         end
         if (noise > 0) drive(k, d, 1'b0);
      end
   endtask

   task automatic wait_idle(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge CLK);
         if (!busyv(k) && rdy(k)) ok = 1'b1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL idle_timeout dut%0d: busy=%b ready=%b want 0 1", k, busyv(k), rdy(k));
      end
   endtask

   initial begin
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);
      RST = 1'b1;
      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("post_reset_ready_a", a_if.IN_READY, 1'b1);
      chk("post_reset_ready_b", b_if.IN_READY, 1'b1);
      chk("post_reset_out_a", out_a, 1'b1);
      chk("post_reset_busy_a", busy_a, 1'b0);

      send(0, 8'hA5, 0, 1'b0);
      wait_idle(0);

      send(1, 8'h01, 0, 1'b0);
      wait_idle(1);

      // Back-to-back with IN_VALID held: exactly one idle cycle between frames
      send(0, 8'hFF, 0, 1'b1);
      a_if.IN_DATA = 8'h00;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            if (done_a) seen = 1'b1;
         end
         chk("b2b_done_seen", seen, 1'b1);
      end
      @(negedge CLK);
      chk("b2b_gap_busy", busy_a, 1'b0);
      chk("b2b_gap_out", out_a, 1'b1);
      chk("b2b_gap_ready", a_if.IN_READY, 1'b1);
      @(negedge CLK);
      chk("b2b_second_start_busy", busy_a, 1'b1);
      chk("b2b_second_start_out", out_a, 1'b0);
      a_if.IN_VALID = 1'b0;
      wait_idle(0);

      // Word offered while busy must be ignored
      send(0, 8'h5A, 0, 1'b0);
      repeat (8) @(negedge CLK);
      drive(0, 8'h3C, 1'b1);
      @(negedge CLK);
      drive(0, 8'h3C, 1'b0);
      wait_idle(0);
      repeat (3) @(negedge CLK);
      chk("no_extra_frame", busy_a, 1'b0);

      // Reset during data bit 3: line returns to idle asynchronously
      send(0, 8'h96, 0, 1'b0);
      repeat (17) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("async_reset_out", out_a, 1'b1);
      chk("async_reset_busy", busy_a, 1'b0);
      chk("async_reset_done", done_a, 1'b0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      send(0, 8'h81, 0, 1'b0);
      wait_idle(0);

      for (int n = 0; n < 16; n++) begin
         send(0, 8'($urandom), int'($urandom_range(0, 30)), 1'b0);
         if ($urandom % 2 == 1) wait_idle(0);
      end
      wait_idle(0);
      for (int n = 0; n < 10; n++) begin
         send(1, 8'($urandom), int'($urandom_range(0, 6)), 1'b0);
         if ($urandom % 2 == 1) wait_idle(1);
      end
      wait_idle(1);

      repeat (4) @(negedge CLK);
      tests++;
      if (q0.size() != 0 || act[0]) begin
         fails++;
         $display("FAIL drain_a: pending=%0d active=%b want 0 0", q0.size(), act[0]);
      end
      tests++;
      if (q1.size() != 0 || act[1]) begin
         fails++;
         $display("FAIL drain_b: pending=%0d active=%b want 0 0", q1.size(), act[1]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
